// File: rtl/prio_encoder_rr.sv
// Purpose: priority encoder with selectable fixed (highest index wins) or round-robin arbitration.
// Latency: 1 cycle from accept to registered result on out_idx/out_zero.
// Backpressure: in_ready = !out_valid || out_ready; the result is held while out_ready is low.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   in_valid   - in_req/mode valid this cycle
//   in_ready   - block accepts input this cycle
//   in_req     - N-bit request vector, bit i = request from source i
//   mode       - 0 = fixed priority, 1 = round-robin (sampled with in_valid)
//   out_valid  - out_idx/out_zero hold a result
//   out_ready  - downstream consumes the result this cycle
//   out_idx    - encoded winning index
//   out_zero   - the accepted request vector was all zeros
module prio_encoder_rr #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_req,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_zero
);

  localparam int W = $clog2(N);

  // Round-robin pointer: first index searched on the next round-robin accept.
  logic [W-1:0] ptr;

  logic         accept;
  logic         any_req;
  logic [W-1:0] fix_idx;
  logic         hi_found;
  logic [W-1:0] hi_idx;
  logic [W-1:0] lo_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] win_idx;
  logic [W-1:0] ptr_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    any_req = |in_req;

    // Fixed priority: ascending scan, the last hit is the highest set bit.
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (in_req[i]) fix_idx = W'(i);
    end

    // Round-robin: a descending scan leaves the lowest set bit at or above
    // ptr in hi_idx and the lowest set bit overall in lo_idx. When nothing is
    // set at or above ptr the search wraps, so lo_idx is the winner.
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_req[i]) begin
        lo_idx = W'(i);
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = W'(i);
        end
      end
    end
    rr_idx = hi_found ? hi_idx : lo_idx;

    win_idx = mode ? rr_idx : fix_idx;

    // Explicit wrap so non-power-of-2 N never leaves ptr outside 0..N-1.
    ptr_nxt = (rr_idx == W'(N - 1)) ? '0 : rr_idx + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_zero  <= 1'b0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_idx   <= any_req ? win_idx : '0;
      out_zero  <= !any_req;
      // Only a non-empty round-robin accept advances the pointer.
      if (mode && any_req) ptr <= ptr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/prio_encoder_rr.md
PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of request inputs; legal range 2..64.
REQ-002 The block SHALL derive localparam W = $clog2(N), the index width, and SHALL NOT expose it as an overridable parameter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_req and mode are valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-007 The block SHALL have port in_req, input, N bits: request vector; bit i means request from source i.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 selects fixed priority, 1 selects round-robin; sampled with in_valid.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the out_idx/out_zero result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumes the result this cycle.
REQ-011 The block SHALL have port out_idx, output, W bits: the encoded winning index.
REQ-012 The block SHALL have port out_zero, output, 1 bit: the accepted in_req was all zeros.

Function
REQ-013 The block SHALL accept an input (an accept) when in_valid && in_ready at a rising edge.
REQ-014 in_ready SHALL equal !out_valid || out_ready, combinationally, with no other dependency.
REQ-015 The block SHALL present the result of an accept on out_idx/out_zero, with out_valid=1, on the cycle after the accept (latency 1).
REQ-016 The block SHALL hold out_valid, out_idx and out_zero stable while out_valid && !out_ready.
REQ-017 When out_valid && out_ready and there is no accept in the same cycle, out_valid SHALL go to 0 next cycle.
REQ-018 When out_valid && out_ready and there is an accept in the same cycle, the new result SHALL replace the old one with no bubble.
REQ-019 In fixed mode (mode=0), the winner SHALL be the highest set bit index of in_req.
REQ-020 The block SHALL keep an internal pointer ptr, W bits wide, ranging 0..N-1.
REQ-021 In round-robin mode (mode=1), the search order SHALL be ptr, ptr+1, ..., N-1, 0, ..., ptr-1, and the first set bit in that order SHALL win.
REQ-022 After a round-robin accept with winner g, ptr SHALL become g+1, wrapping to 0 when g = N-1, including for N not a power of 2.
REQ-023 A fixed-mode accept SHALL NOT change ptr; ptr SHALL be retained across mode switches.
REQ-024 An all-zero in_req SHALL produce out_zero=1 and out_idx=0, and SHALL leave ptr unchanged in either mode.
REQ-025 A single-bit in_req SHALL produce the index of that bit in both modes, matching plain encoder behaviour.
REQ-026 While in_valid=0 or in_ready=0, in_req and mode SHALL be ignored and no state SHALL change except per REQ-017.

Reset
REQ-027 When rst=1 at a rising edge, the next state SHALL be out_valid=0, out_idx=0, out_zero=0 and ptr=0, regardless of other inputs.
REQ-028 Reset SHALL take priority over a simultaneous accept; the input presented in that cycle SHALL be discarded.
REQ-029 While rst=1, in_ready SHALL follow REQ-014 (it reads 1 once out_valid=0), but no accept SHALL take effect.
REQ-030 Reset applied while out_valid=1 (mid-operation) SHALL drop the pending result; no stale value SHALL reappear after reset.

Verification (N=8)
REQ-031 The bench SHALL cover: mode=0, in_req=8'b0001_0110 -> out_idx=4, out_zero=0, out_valid=1 one cycle later.
REQ-032 The bench SHALL cover: after reset, mode=1, three accepts of in_req=8'b1000_0100 -> out_idx 2, 7, 2; ptr after each is 3, 0, 3.
REQ-033 The bench SHALL cover: out_ready=0 for 3 cycles after a result -> out_idx held and in_ready=0; then out_ready=1 with in_valid=1 and in_req=8'b0000_0001 -> next cycle out_idx=0, out_valid=1, no bubble.
REQ-034 The bench SHALL cover: in_req=0 in mode=1 with ptr=5 -> out_zero=1, out_idx=0, ptr remains 5.
REQ-035 The bench SHALL cover: rst=1 asserted with out_valid=1 and a simultaneous accept -> next cycle out_valid=0, ptr=0, and the input is discarded.
REQ-036 The bench SHALL cover: N=5 parameter override, mode=1, in_req=5'b10001 repeated -> out_idx 0, 4, 0, with ptr wrapping 4 -> 0 correctly.
